parity_stream_unit: RTL and testbench

- Sequential, parametrised successor to the combinational N-input XOR parity gate.
- Accumulates XOR parity over a multi-beat frame of WIDTH-bit words received on a valid/ready stream.
- Per frame, emits one result: generated parity, or a check result against a received parity bit.
- Sits between a word-stream source and a link/framing block.

---
 rtl/parity_stream_unit_pkg.sv | 17 +
 rtl/parity_stream_unit_xor.sv | 13 +
 rtl/parity_stream_unit.sv | 112 +++++++++++
 tb/tb_parity_stream_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_stream_unit_pkg.sv
// Shared encodings and sizing helpers for the parity stream unit.
package parity_stream_unit_pkg;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Beat counter must hold the value MAX_BEATS itself (reported in out_beats).
  function automatic int unsigned cw_width(input int unsigned max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/parity_stream_unit_xor.sv
// Parametrised N-input XOR reduction gate; used as the per-word parity stage.
module parity_stream_unit_xor #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] in_bits,
  output logic         parity
);

  always_comb begin
    parity = ^in_bits;
  end

endmodule

// File: rtl/parity_stream_unit.sv
// Frame-level XOR parity accumulator on a valid/ready word stream; emits
// one generated-parity or check result per frame through a held output.
module parity_stream_unit
  import parity_stream_unit_pkg::*;
#(
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned ODD       = 0,
  parameter  int unsigned MAX_BEATS = 16,
  localparam int unsigned CW        = cw_width(MAX_BEATS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_error,
  output logic [CW-1:0]    out_beats,
  output logic             out_ovf
);

  localparam logic ODD_BIT = 1'(ODD);

  state_t          state_q;
  state_t          state_d;
  logic            started_q;
  logic            acc_q;
  logic [CW-1:0]   count_q;
  logic            mode_q;

  logic            word_par;
  logic            xfer;
  logic            at_max;
  logic            frame_end;
  logic            mode_eff;
  logic            par_next;

  parity_stream_unit_xor #(.N(WIDTH)) u_word_xor (
    .in_bits (in_data),
    .parity  (word_par)
  );

  // started_q keeps in_ready low until the first clock after reset release.
  assign out_valid = (state_q == HOLD);
  assign in_ready  = started_q && (!out_valid || out_ready);
  assign xfer      = in_valid && in_ready;
  assign at_max    = (count_q == CW'(MAX_BEATS - 1));
  assign frame_end = xfer && (in_last || at_max);
  assign mode_eff  = (count_q == '0) ? mode : mode_q;
  assign par_next  = acc_q ^ word_par ^ ODD_BIT;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM: begin
        if (frame_end) state_d = HOLD;
      end
      HOLD: begin
        if (frame_end)      state_d = HOLD;
        else if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= 1'b0;
      count_q <= '0;
      mode_q  <= MODE_GEN;
    end else if (xfer) begin
      if (count_q == '0) mode_q <= mode;
      if (frame_end) begin
        acc_q   <= 1'b0;
        count_q <= '0;
      end else begin
        acc_q   <= acc_q ^ word_par;
        count_q <= count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
      out_error  <= 1'b0;
      out_beats  <= '0;
      out_ovf    <= 1'b0;
    end else if (frame_end) begin
      out_parity <= par_next;
      out_error  <= (mode_eff == MODE_CHK) && (par_next != in_par);
      out_beats  <= count_q + CW'(1);
      out_ovf    <= at_max && !in_last;
    end
  end

endmodule

// File: tb/tb_parity_stream_unit.sv
// Randomized and directed bench for parity_stream_unit across four parameter sets,
// checked every cycle against a frame-level model built on bit counts.
module tb_parity_stream_unit;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_par;
  logic       out_ready;

  logic [3:0] rdy;
  logic [3:0] vld;
  logic [3:0] opar;
  logic [3:0] oerr;
  logic [3:0] oovf;
  logic [4:0] beats_a;
  logic [4:0] beats_b;
  logic [2:0] beats_c;
  logic [0:0] beats_d;

  int total;
  int bad;

  typedef struct {
    bit started;
    bit valid;
    bit par;
    bit err;
    int beats;
    bit ovf;
    int n;
    int ones;
    bit fmode;
  } mst_t;

  mst_t ms [4];

  parity_stream_unit #(.WIDTH(8), .ODD(0), .MAX_BEATS(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .in_last(in_last), .in_par(in_par), .out_valid(vld[0]),
    .out_ready(out_ready), .out_parity(opar[0]), .out_error(oerr[0]),
    .out_beats(beats_a), .out_ovf(oovf[0]));

  parity_stream_unit #(.WIDTH(8), .ODD(1), .MAX_BEATS(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .in_last(in_last), .in_par(in_par), .out_valid(vld[1]),
    .out_ready(out_ready), .out_parity(opar[1]), .out_error(oerr[1]),
    .out_beats(beats_b), .out_ovf(oovf[1]));

  parity_stream_unit #(.WIDTH(8), .ODD(0), .MAX_BEATS(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data), .in_last(in_last), .in_par(in_par), .out_valid(vld[2]),
    .out_ready(out_ready), .out_parity(opar[2]), .out_error(oerr[2]),
    .out_beats(beats_c), .out_ovf(oovf[2]));

  parity_stream_unit #(.WIDTH(8), .ODD(0), .MAX_BEATS(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(rdy[3]),
    .in_data(in_data), .in_last(in_last), .in_par(in_par), .out_valid(vld[3]),
    .out_ready(out_ready), .out_parity(opar[3]), .out_error(oerr[3]),
    .out_beats(beats_d), .out_ovf(oovf[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_mb(input int d);
    case (d)
      0, 1:    return 16;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic bit cfg_odd(input int d);
    return (d == 1);
  endfunction

  function automatic logic [31:0] get_beats(input int d);
    case (d)
      0:       return 32'(beats_a);
      1:       return 32'(beats_b);
      2:       return 32'(beats_c);
      default: return 32'(beats_d);
    endcase
  endfunction

  // Frame model: parity is the total count of one bits in the frame, mod 2.
  function automatic mst_t step(input mst_t s, input int d);
    mst_t r;
    bit   ready;
    bit   m;
    r = s;
    ready = s.started && (!s.valid || out_ready);
    r.started = 1'b1;
    if (s.valid && out_ready) r.valid = 1'b0;
    if (ready && in_valid) begin
      m = (s.n == 0) ? mode : s.fmode;
      r.fmode = m;
      r.n = s.n + 1;
      r.ones = s.ones + $countones(in_data);
      if (in_last || r.n == cfg_mb(d)) begin
        r.valid = 1'b1;
        r.par   = ((r.ones % 2) != 0) ^ cfg_odd(d);
        r.err   = m && (r.par != in_par);
        r.beats = r.n;
        r.ovf   = (r.n == cfg_mb(d)) && !in_last;
        r.n     = 0;
        r.ones  = 0;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 4; d++) ms[d] <= '{default: 0};
    end else begin
      for (int d = 0; d < 4; d++) ms[d] <= step(ms[d], d);
    end
  end

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 4; d++) begin
      if (!rst_n) begin
        chk("rst_ready", d, 32'(rdy[d]), 0);
        chk("rst_valid", d, 32'(vld[d]), 0);
        chk("rst_parity", d, 32'(opar[d]), 0);
        chk("rst_error", d, 32'(oerr[d]), 0);
        chk("rst_beats", d, get_beats(d), 0);
        chk("rst_ovf", d, 32'(oovf[d]), 0);
      end else begin
        chk("ready", d, 32'(rdy[d]), 32'(ms[d].started && (!ms[d].valid || out_ready)));
        chk("valid", d, 32'(vld[d]), 32'(ms[d].valid));
        if (ms[d].valid) begin
          chk("parity", d, 32'(opar[d]), 32'(ms[d].par));
          chk("error", d, 32'(oerr[d]), 32'(ms[d].err));
          chk("beats", d, get_beats(d), 32'(ms[d].beats));
          chk("ovf", d, 32'(oovf[d]), 32'(ms[d].ovf));
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] data, input bit last, input bit p, input bit md);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    in_par   = p;
    mode     = md;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b1;
    mode = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    in_par = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", 0, 32'(rdy[0]), 1);

    // Single-beat frame, generate mode.
    beat(8'hA5, 1, 0, 0);
    chk("t1_valid", 0, 32'(vld[0]), 1);
    chk("t1_parity", 0, 32'(opar[0]), 0);
    chk("t1_beats", 0, get_beats(0), 1);
    chk("t1_error", 0, 32'(oerr[0]), 0);
    chk("t1_model_par", 0, 32'(ms[0].par), 0);
    chk("t1_odd_parity", 1, 32'(opar[1]), 1);

    // Three-beat frame.
    beat(8'h01, 0, 0, 0);
    beat(8'h03, 0, 0, 0);
    beat(8'h07, 1, 0, 0);
    chk("t2_parity", 0, 32'(opar[0]), 0);
    chk("t2_beats", 0, get_beats(0), 3);
    chk("t2_odd_parity", 1, 32'(opar[1]), 1);
    chk("t2_model_beats", 0, 32'(ms[0].beats), 3);
    chk("t2_mb1_parity", 3, 32'(opar[3]), 1);

    // Check mode; third frame drops mode mid-frame, which must be ignored.
    beat(8'h01, 0, 0, 1);
    beat(8'h80, 1, 1, 1);
    chk("t3_err_set", 0, 32'(oerr[0]), 1);
    chk("t3_parity", 0, 32'(opar[0]), 0);
    beat(8'h01, 0, 0, 1);
    beat(8'h80, 1, 0, 1);
    chk("t3_err_clr", 0, 32'(oerr[0]), 0);
    beat(8'h01, 0, 0, 1);
    beat(8'h80, 1, 1, 0);
    chk("t3_mode_latched", 0, 32'(oerr[0]), 1);
    chk("t3_model_err", 0, 32'(ms[0].err), 1);
    tick();

    // Backpressure, then zero-bubble release.
    out_ready = 1'b0;
    beat(8'h03, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
      in_last  = 1'b1;
      tick();
      chk("bp_ready", 0, 32'(rdy[0]), 0);
      chk("bp_parity", 0, 32'(opar[0]), 0);
      chk("bp_beats", 0, get_beats(0), 1);
    end
    out_ready = 1'b1;
    beat(8'h01, 1, 0, 0);
    chk("bp_next_valid", 0, 32'(vld[0]), 1);
    chk("bp_next_parity", 0, 32'(opar[0]), 1);
    tick();

    // Truncation at MAX_BEATS=4 (dut_c) and MAX_BEATS=1 (dut_d).
    for (int i = 0; i < 3; i++) beat(8'h01, 0, 0, 0);
    chk("mb1_ovf", 3, 32'(oovf[3]), 1);
    chk("mb1_beats", 3, get_beats(3), 1);
    beat(8'h01, 0, 0, 0);
    chk("ovf_valid", 2, 32'(vld[2]), 1);
    chk("ovf_beats", 2, get_beats(2), 4);
    chk("ovf_flag", 2, 32'(oovf[2]), 1);
    chk("ovf_parity", 2, 32'(opar[2]), 0);
    beat(8'h01, 0, 0, 0);
    beat(8'h01, 1, 0, 0);
    chk("ovf2_beats", 2, get_beats(2), 2);
    chk("ovf2_flag", 2, 32'(oovf[2]), 0);
    chk("ovf2_parity", 2, 32'(opar[2]), 0);
    chk("six_beats", 0, get_beats(0), 6);

    // Reset mid-frame discards the partial frame.
    beat(8'h01, 0, 0, 0);
    beat(8'h01, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    beat(8'h01, 1, 0, 0);
    chk("rst_mid_parity", 0, 32'(opar[0]), 1);
    chk("rst_mid_beats", 0, get_beats(0), 1);
    chk("rst_mid_ovf", 0, 32'(oovf[0]), 0);

    // Randomized traffic: first stretch at full throughput, then random backpressure.
    for (int i = 0; i < 4000; i++) begin
      if (i > 1000 && $urandom_range(0, 499) == 0) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 4) == 0);
      mode      = 1'($urandom);
      in_par    = 1'($urandom);
      out_ready = (i < 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
